// File: rtl/mem_stage_if.sv
// Byte-serial data-memory port used by the memory-access stage.
//
// Handshake: the master raises mem_req_o and holds mem_we_o, mem_addr_o and
// mem_wdata_o stable until the slave answers. One byte transfer completes in
// every cycle where mem_req_o and mem_ack_i are both 1. For reads,
// mem_rdata_i is sampled in that same cycle. mem_ack_i while mem_req_o is 0
// means nothing. The master may keep mem_req_o high across consecutive bytes;
// address and data then change only in the cycle after an ack.
interface mem_stage_if #(
    parameter int MEM_ADDR_WIDTH = 32
) ();
    logic                      mem_req_o;
    logic                      mem_we_o;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
    logic [7:0]                mem_wdata_o;
    logic                      mem_ack_i;
    logic [7:0]                mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline. Non-memory instructions pass
// through to the mem/wb register in one cycle. Loads and stores are split into
// 1, 2 or 4 little-endian byte transfers on the byte-serial memory port.
// The upstream stages are held through stallreq_o until the last byte is acked.
module mem_stage #(
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic        stallreq_o,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    mem_stage_if.master mem,
    output logic        dbg_state_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] rbuf_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [3:0]  op_q;
    logic [4:0]  wd_q;
    logic        wreg_q;

    logic        accept;
    logic        xfer;
    logic        last_xfer;
    logic        store_q;
    logic [1:0]  last_idx;
    logic [31:0] addr_sum;
    logic [31:0] merged;
    logic [31:0] load_result;
    logic [7:0]  sbyte;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Index of the final byte: size minus one.
    function automatic logic [1:0] last_index(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

    assign accept    = (state_q == IDLE) && valid_i && is_mem_op(mem_op_i);
    assign store_q   = is_store_op(op_q);
    assign last_idx  = last_index(op_q);
    assign xfer      = (state_q == ACCESS) && mem.mem_ack_i;
    assign last_xfer = xfer && (cnt_q == last_idx);
    // Byte address wraps naturally at the top of the 32-bit space.
    assign addr_sum  = addr_q + {30'd0, cnt_q};
    assign dbg_state_o = (state_q == ACCESS);

    // Capture buffer with the byte arriving this cycle merged in, so the
    // final result can be formed in the same cycle as the last ack.
    always_comb begin
        merged = rbuf_q;
        sbyte  = sdata_q[7:0];
        case (cnt_q)
            2'd0: begin merged[7:0]   = mem.mem_rdata_i; sbyte = sdata_q[7:0];   end
            2'd1: begin merged[15:8]  = mem.mem_rdata_i; sbyte = sdata_q[15:8];  end
            2'd2: begin merged[23:16] = mem.mem_rdata_i; sbyte = sdata_q[23:16]; end
            default: begin merged[31:24] = mem.mem_rdata_i; sbyte = sdata_q[31:24]; end
        endcase
    end

    // Sign/zero extension of the assembled load data.
    always_comb begin
        load_result = 32'd0;
        case (op_q)
            OP_LB:   load_result = {{24{merged[7]}}, merged[7:0]};
            OP_LH:   load_result = {{16{merged[15]}}, merged[15:0]};
            OP_LW:   load_result = merged;
            OP_LBU:  load_result = {24'd0, merged[7:0]};
            OP_LHU:  load_result = {16'd0, merged[15:0]};
            default: load_result = 32'd0;
        endcase
    end

    // Next-state logic, byte counter, memory port drive and stall request.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        stallreq_o      = 1'b0;
        mem.mem_req_o   = 1'b0;
        mem.mem_we_o    = 1'b0;
        mem.mem_addr_o  = '0;
        mem.mem_wdata_o = 8'd0;
        case (state_q)
            IDLE: begin
                stallreq_o = accept;
                if (accept) begin
                    state_d = ACCESS;
                    cnt_d   = 2'd0;
                end
            end
            ACCESS: begin
                mem.mem_req_o   = 1'b1;
                mem.mem_we_o    = store_q;
                mem.mem_addr_o  = addr_sum[MEM_ADDR_WIDTH-1:0];
                mem.mem_wdata_o = sbyte;
                // Dropping stall on the final ack lets upstream advance on
                // the same edge, so there is no bubble between accesses.
                stallreq_o      = !last_xfer;
                if (xfer) begin
                    if (cnt_q == last_idx) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State register and byte counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Instruction latch, captured when a memory op is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q    <= 5'd0;
            wreg_q  <= 1'b0;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
        end else if (accept) begin
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
            op_q    <= mem_op_i;
            addr_q  <= mem_addr_i;
            sdata_q <= mem_sdata_i;
        end
    end

    // Load capture buffer, filled one byte per acked read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbuf_q <= 32'd0;
        end else if (accept) begin
            rbuf_q <= 32'd0;
        end else if (xfer && !store_q) begin
            rbuf_q <= merged;
        end
    end

    // mem/wb register: passthrough results and completed accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            wd_o    <= 5'd0;
            wreg_o  <= 1'b0;
            wdata_o <= 32'd0;
        end else if (state_q == IDLE) begin
            if (valid_i && !is_mem_op(mem_op_i)) begin
                valid_o <= 1'b1;
                wd_o    <= wd_i;
                wreg_o  <= wreg_i;
                wdata_o <= wdata_i;
            end else begin
                valid_o <= 1'b0;
                wreg_o  <= 1'b0;
            end
        end else if (last_xfer) begin
            valid_o <= 1'b1;
            wd_o    <= wd_q;
            wreg_o  <= store_q ? 1'b0 : wreg_q;
            wdata_o <= store_q ? 32'd0 : load_result;
        end else begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized instruction stream plus directed cases,
// checked every cycle against a transaction-level model of the stage.
module tb_mem_stage;
    localparam int AW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid_i = 1'b0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic [3:0]  mem_op_i = 4'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] mem_sdata_i = 32'd0;
    logic        stallreq_o;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        dbg_state_o;

    mem_stage_if #(.MEM_ADDR_WIDTH(AW)) mif ();

    mem_stage #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .stallreq_o  (stallreq_o),
        .valid_o     (valid_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .mem         (mif),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // ---------------- memory image and reference rules ----------------
    logic [7:0] mem_img [logic [31:0]];

    function automatic logic [7:0] rd_byte(input logic [31:0] ba);
        if (mem_img.exists(ba)) return mem_img[ba];
        return ba[7:0] ^ 8'h5A;
    endfunction

    function automatic bit op_mem(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] base);
        logic [7:0] b0, b1, b2, b3;
        b0 = rd_byte(base);
        b1 = rd_byte(base + 32'd1);
        b2 = rd_byte(base + 32'd2);
        b3 = rd_byte(base + 32'd3);
        case (op)
            4'd1:    return {{24{b0[7]}}, b0};
            4'd2:    return {{16{b1[7]}}, b1, b0};
            4'd3:    return {b3, b2, b1, b0};
            4'd4:    return {24'd0, b0};
            4'd5:    return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- model state ----------------
    bit          m_busy = 1'b0;
    int          m_done = 0;
    int          m_n = 0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_sdata = 32'd0;
    bit          m_valid_exp = 1'b0;
    logic [37:0] exp_q[$];           // {wd, wreg, wdata}
    logic [40:0] xfer_log[$];        // {we, addr, byte}
    bit          up_adv = 1'b0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          valid_cyc = 0;
    int          valid_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] last_wdata = 32'd0;
    logic        last_wreg = 1'b0;

    // ---------------- memory responder ----------------
    int wait_mode = 0;    // 0 zero-wait, 1 three waits, 2 random 0..3
    bit spurious_en = 1'b0;
    int wait_left = -1;

    function automatic int pick_wait();
        case (wait_mode)
            0:       return 0;
            1:       return 3;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        mif.mem_ack_i   = 1'b0;
        mif.mem_rdata_i = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mif.mem_req_o) begin
                if (wait_left < 0) wait_left = pick_wait();
                if (wait_left == 0) begin
                    mif.mem_ack_i   = 1'b1;
                    mif.mem_rdata_i = mif.mem_we_o ? 8'h00 : rd_byte(32'(mif.mem_addr_o));
                    wait_left = -1;
                end else begin
                    mif.mem_ack_i   = 1'b0;
                    mif.mem_rdata_i = 8'($urandom);
                    wait_left--;
                end
            end else begin
                wait_left       = -1;
                mif.mem_ack_i   = spurious_en && ($urandom_range(0, 3) == 0);
                mif.mem_rdata_i = 8'($urandom);
            end
        end
    end

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [31:0] cur_addr;
        logic [37:0] e;
        logic [7:0]  sb;
        bit          next_valid;
        bit          exp_stall;
        cyc++;
        if (stallreq_o) stall_cnt++;
        if (!rst) begin
            chk("rst_valid_o", 32'(valid_o), 32'd0);
            chk("rst_mem_req", 32'(mif.mem_req_o), 32'd0);
            m_busy = 1'b0;
            m_valid_exp = 1'b0;
            exp_q.delete();
            up_adv = 1'b0;
        end else begin
            chk("valid_o", 32'(valid_o), 32'(m_valid_exp));
            if (valid_o) begin
                valid_cnt++;
                valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wd_o", 32'(wd_o), 32'(e[37:33]));
                    chk("wreg_o", 32'(wreg_o), 32'(e[32]));
                    chk("wdata_o", wdata_o, e[31:0]);
                    last_wdata = wdata_o;
                    last_wreg = wreg_o;
                end
            end
            exp_stall = m_busy ? !(mif.mem_ack_i && (m_done == m_n - 1))
                               : (valid_i && op_mem(mem_op_i));
            chk("stallreq_o", 32'(stallreq_o), 32'(exp_stall));
            chk("mem_req_o", 32'(mif.mem_req_o), 32'(m_busy));
            cur_addr = m_addr + 32'(m_done);
            sb = m_sdata[8*m_done +: 8];
            if (m_busy) begin
                chk("mem_addr_o", 32'(mif.mem_addr_o), cur_addr);
                chk("mem_we_o", 32'(mif.mem_we_o), 32'(op_store(m_op)));
                if (op_store(m_op)) chk("mem_wdata_o", 32'(mif.mem_wdata_o), 32'(sb));
            end
            // advance the model to the coming edge
            up_adv = valid_i && !exp_stall;
            next_valid = 1'b0;
            if (m_busy) begin
                if (mif.mem_ack_i) begin
                    xfer_log.push_back({op_store(m_op), cur_addr,
                                        op_store(m_op) ? sb : mif.mem_rdata_i});
                    if (op_store(m_op)) mem_img[cur_addr] = sb;
                    m_done++;
                    if (m_done == m_n) begin
                        m_busy = 1'b0;
                        next_valid = 1'b1;
                    end
                end
            end else if (valid_i) begin
                accept_cyc = cyc;
                if (op_mem(mem_op_i)) begin
                    m_busy  = 1'b1;
                    m_done  = 0;
                    m_n     = op_size(mem_op_i);
                    m_op    = mem_op_i;
                    m_addr  = mem_addr_i;
                    m_sdata = mem_sdata_i;
                    if (op_store(mem_op_i))
                        exp_q.push_back({wd_i, 1'b0, 32'd0});
                    else
                        exp_q.push_back({wd_i, wreg_i, load_value(mem_op_i, mem_addr_i)});
                end else begin
                    exp_q.push_back({wd_i, wreg_i, wdata_i});
                    next_valid = 1'b1;
                end
            end
            m_valid_exp = next_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a rising edge; returns at the edge where upstream advances.
    task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wr,
                         input logic [31:0] wdat, input logic [31:0] addr,
                         input logic [31:0] sdat);
        int budget;
        #1;
        valid_i     = 1'b1;
        mem_op_i    = op;
        wd_i        = wd;
        wreg_i      = wr;
        wdata_i     = wdat;
        mem_addr_i  = addr;
        mem_sdata_i = sdat;
        budget = 0;
        do begin
            @(posedge clk);
            budget++;
        end while (!up_adv && budget < 300);
        if (!up_adv) begin
            chk("issue_timeout", 32'd0, 32'd1);
            finish_run();
        end
    endtask

    task automatic idle(input int n);
        #1;
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic chk_xfer(input int i, input logic we, input logic [31:0] addr,
                            input logic [7:0] data, input bit check_data);
        if (i >= xfer_log.size()) begin
            chk("xfer_missing", 32'(xfer_log.size()), 32'(i + 1));
        end else begin
            chk("xfer_we", 32'(xfer_log[i][40]), 32'(we));
            chk("xfer_addr", xfer_log[i][39:8], addr);
            if (check_data) chk("xfer_data", 32'(xfer_log[i][7:0]), 32'(data));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        chk("watchdog", 32'd0, 32'd1);
        finish_run();
    end

    // ---------------- main sequence ----------------
    initial begin
        int vc0;
        int s0;
        int budget;
        logic [3:0]  rop;
        logic [31:0] raddr;

        // reset values, checked without any clock edge
        #1 rst = 1'b0;
        #1;
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_wreg_o", 32'(wreg_o), 32'd0);
        chk("reset_wd_o", 32'(wd_o), 32'd0);
        chk("reset_wdata_o", wdata_o, 32'd0);
        chk("reset_mem_req", 32'(mif.mem_req_o), 32'd0);
        chk("reset_mem_we", 32'(mif.mem_we_o), 32'd0);
        chk("reset_mem_addr", 32'(mif.mem_addr_o), 32'd0);
        chk("reset_mem_wdata", 32'(mif.mem_wdata_o), 32'd0);
        chk("reset_stall", 32'(stallreq_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);

        // passthrough, three back-to-back
        vc0 = valid_cnt;
        s0 = stall_cnt;
        issue(4'd0, 5'd5, 1'b1, 32'h11, 32'd0, 32'd0);
        issue(4'd0, 5'd6, 1'b1, 32'h22, 32'd0, 32'd0);
        issue(4'd0, 5'd7, 1'b1, 32'h33, 32'd0, 32'd0);
        idle(3);
        chk("pass_valid_count", 32'(valid_cnt - vc0), 32'd3);
        chk("pass_stall_cycles", 32'(stall_cnt - s0), 32'd0);
        chk("pass_last_wdata", last_wdata, 32'h33);

        // LW zero-wait
        wait_mode = 0;
        mem_img[32'h100] = 8'h78;
        mem_img[32'h101] = 8'h56;
        mem_img[32'h102] = 8'h34;
        mem_img[32'h103] = 8'h12;
        xfer_log.delete();
        s0 = stall_cnt;
        issue(4'd3, 5'd10, 1'b1, 32'h0, 32'h100, 32'h0);
        idle(3);
        chk("lw_wdata", last_wdata, 32'h12345678);
        chk("lw_latency", 32'(valid_cyc - accept_cyc), 32'd5);
        chk("lw_stall_cycles", 32'(stall_cnt - s0), 32'd4);
        for (int i = 0; i < 4; i++) chk_xfer(i, 1'b0, 32'h100 + 32'(i), 8'h0, 1'b0);

        // LB vs LBU, LH
        mem_img[32'h300] = 8'h80;
        issue(4'd1, 5'd11, 1'b1, 32'h0, 32'h300, 32'h0);
        idle(2);
        chk("lb_wdata", last_wdata, 32'hFFFFFF80);
        issue(4'd4, 5'd12, 1'b1, 32'h0, 32'h300, 32'h0);
        idle(2);
        chk("lbu_wdata", last_wdata, 32'h00000080);
        mem_img[32'h310] = 8'hFE;
        mem_img[32'h311] = 8'h7F;
        issue(4'd2, 5'd13, 1'b1, 32'h0, 32'h310, 32'h0);
        idle(2);
        chk("lh_wdata", last_wdata, 32'h00007FFE);

        // SH with three wait cycles per byte
        wait_mode = 1;
        xfer_log.delete();
        issue(4'd7, 5'd14, 1'b1, 32'h0, 32'h203, 32'hAABBCCDD);
        idle(2);
        chk_xfer(0, 1'b1, 32'h203, 8'hDD, 1'b1);
        chk_xfer(1, 1'b1, 32'h204, 8'hCC, 1'b1);
        chk("sh_wreg", 32'(last_wreg), 32'd0);
        chk("sh_wdata", last_wdata, 32'd0);
        chk("sh_mem_203", 32'(rd_byte(32'h203)), 32'hDD);

        // wrap-around at the top of the address space
        wait_mode = 0;
        xfer_log.delete();
        issue(4'd3, 5'd15, 1'b1, 32'h0, 32'hFFFFFFFE, 32'h0);
        idle(2);
        chk_xfer(0, 1'b0, 32'hFFFFFFFE, 8'h0, 1'b0);
        chk_xfer(1, 1'b0, 32'hFFFFFFFF, 8'h0, 1'b0);
        chk_xfer(2, 1'b0, 32'h00000000, 8'h0, 1'b0);
        chk_xfer(3, 1'b0, 32'h00000001, 8'h0, 1'b0);

        // randomized stream
        spurious_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            wait_mode = int'($urandom_range(0, 2));
            rop = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                               : (32'h1000 + 32'($urandom_range(0, 63)));
            issue(rop, 5'($urandom), 1'($urandom), $urandom, raddr, $urandom);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(20);
        spurious_en = 1'b0;

        // reset in the middle of the second byte of an LW
        wait_mode = 1;
        xfer_log.delete();
        vc0 = valid_cnt;
        #1;
        valid_i     = 1'b1;
        mem_op_i    = 4'd3;
        wd_i        = 5'd3;
        wreg_i      = 1'b1;
        mem_addr_i  = 32'h400;
        mem_sdata_i = 32'h0;
        budget = 0;
        do begin
            @(posedge clk);
            budget++;
        end while (xfer_log.size() < 1 && budget < 50);
        chk("rst_mid_first_byte", 32'(xfer_log.size()), 32'd1);
        #3;
        rst = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("rst_mid_req_async", 32'(mif.mem_req_o), 32'd0);
        chk("rst_mid_valid", 32'(valid_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(3);
        chk("rst_mid_no_pulse", 32'(valid_cnt - vc0), 32'd0);
        issue(4'd0, 5'd9, 1'b1, 32'h0000CAFE, 32'h0, 32'h0);
        idle(2);
        chk("post_reset_valid_count", 32'(valid_cnt - vc0), 32'd1);
        chk("post_reset_wdata", last_wdata, 32'h0000CAFE);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        finish_run();
    end
endmodule
